sync_fifo: RTL
==============

// Module: sync_fifo
// PURPOSE
//  - Single-clock FIFO: pointer/flag control plus storage in the team's existing dual-port RAM (ram_2ports).
//  - Sits between a producer and a consumer in the sequential datapath, absorbing rate mismatch.
//  - Read is first-word-fall-through: rd_data shows the head entry whenever empty=0.
// PARAMETERS
//  - ADDR_WIDTH  3  log2 of FIFO depth; depth = 2**ADDR_WIDTH
//  - DATA_WIDTH  8  entry width in bits
//  - AF_LEVEL    6  almost_full threshold, used only with FIFO_ALMOST_EN
//  - AE_LEVEL    1  almost_empty threshold, used only with FIFO_ALMOST_EN
// PORTS
//  - clk           in   1           single clock; all state updates on posedge
//  - rst_n         in   1           reset: asynchronous, active-low
//  - wr            in   1           write request
//  - w_data        in   DATA_WIDTH  write data, sampled on an accepted write
//  - rd            in   1           read request; pops the head entry
//  - rd_data       out  DATA_WIDTH  head entry; combinational from RAM; undefined while empty=1
//  - full          out  1           no free slot
//  - empty         out  1           no stored entry
//  - overflow      out  1           sticky: a write was attempted while full
//  - underflow     out  1           sticky: a read was attempted while empty
//  - almost_full   out  1           FIFO_ALMOST_EN only: count >= AF_LEVEL
//  - almost_empty  out  1           FIFO_ALMOST_EN only: count <= AE_LEVEL
// BEHAVIOUR
//  - Reset (async, rst_n=0): wptr=rptr=0, empty=1, full=0, overflow=0, underflow=0;
//    almost_empty=1, almost_full=0. RAM contents are not cleared.
//  - Pointers: wptr and rptr are ADDR_WIDTH+1 bits. Low bits address the RAM; the MSB is the wrap bit.
//  - empty = (wptr == rptr). full = low bits equal and MSBs differ. Both are pure functions of registered pointers.
//  - Write acceptance: wr_ok = wr & ~full. The RAM write enable is wr_ok, the write address is wptr low bits.
//    On an accepted write, wptr increments modulo 2**(ADDR_WIDTH+1).
//  - Read acceptance: rd_ok = rd & ~empty. The RAM read address is rptr low bits.
//    On an accepted read, rptr increments. The next entry appears on rd_data in the following cycle.
//  - Latency: data written in cycle N is visible on rd_data with empty=0 after the posedge ending cycle N (1 cycle).
//  - Simultaneous wr & rd when neither full nor empty: both accepted, occupancy unchanged, flags unchanged.
//  - Simultaneous wr & rd when full: only the read is accepted. The write is dropped and overflow is set.
//  - Simultaneous wr & rd when empty: only the write is accepted. The read is dropped and underflow is set.
//  - Dropped operations never move a pointer. overflow and underflow clear only on reset.
//  - Wrap-around: low pointer bits roll from 2**ADDR_WIDTH-1 to 0 and the MSB toggles.
//    Full and empty stay exact across any number of wraps.
//  - Reset asserted mid-operation: the FIFO is empty immediately and asynchronously.
//    In-flight requests in that cycle are ignored.
// CONFIGURATION
//  - Macro FIFO_ALMOST_EN.
//  - Defined: adds a registered count (ADDR_WIDTH+1 bits) and the almost_full/almost_empty outputs.
//    count is updated by the same accepted-op rules; both flags are combinational from count.
//  - Undefined: no count register, and almost_full/almost_empty are absent from the port list.
// STRUCTURE
//  - Shared header fifo_defs.vh: default ADDR_WIDTH/DATA_WIDTH, and the `define FIFO_ALMOST_EN switch.
//  - Sub-module fifo_ctrl: pointers, full/empty, sticky error flags, optional count.
//    It outputs we, w_addr and r_addr.
//  - Top level: instantiates fifo_ctrl and ram_2ports, wiring we/w_addr/r_addr/w_data/r_data straight through.
// TESTING
//  - Reset then idle -> empty=1, full=0, overflow=0, underflow=0; rd=1 for 1 cycle -> underflow=1, rptr unchanged.
//  - Write 8 values 0x11..0x88 (depth 8) -> full=1 after the 8th; a 9th write 0x99 -> overflow=1, data lost.
//  - Read 8 values -> rd_data returns 0x11..0x88 in order; empty=1 after the 8th read.
//  - Fill 4 entries, then 20 cycles of simultaneous wr/rd with an incrementing pattern
//    -> order preserved across pointer wrap; full=0 and empty=0 throughout.
//  - Full FIFO with wr=rd=1 -> head popped, write dropped, overflow=1, full=0 next cycle.
//  - Pulse rst_n low mid-stream between clock edges -> empty=1 immediately;
//    with FIFO_ALMOST_EN, almost_empty=1 and count=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and op classification for the sync_fifo slice.
// Optional almost_full/almost_empty support is enabled by defining FIFO_ALMOST_EN.
package sync_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_AF_LEVEL   = 6;
  localparam int DEFAULT_AE_LEVEL   = 1;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e classify_op(input logic wr_ok, input logic rd_ok);
    op_e op;
    case ({rd_ok, wr_ok})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ram_2ports.sv
// Simple dual-port RAM: synchronous write port, combinational read port.
// Contents are never reset.
module ram_2ports #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// fifo_ctrl: wrap-bit pointers, full/empty, sticky overflow/underflow and,
// when FIFO_ALMOST_EN is defined, an occupancy count with almost flags.
module fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef FIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL   = DEFAULT_AF_LEVEL,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                wr_ok;
  logic                rd_ok;
  op_e                 op;

  // Extra MSB distinguishes a full ring from an empty one at equal addresses.
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
            (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  end

  assign wr_ok  = wr & ~full;
  assign rd_ok  = rd & ~empty;
  assign op     = classify_op(wr_ok, rd_ok);
  assign we     = wr_ok;
  assign w_addr = wptr[ADDR_WIDTH-1:0];
  assign r_addr = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (op == OP_PUSH || op == OP_BOTH) wptr <= wptr + PTR_ONE;
      if (op == OP_POP  || op == OP_BOTH) rptr <= rptr + PTR_ONE;
    end
  end

  // Sticky error flags record any rejected request until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + PTR_ONE;
        OP_POP:  count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);
`endif

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through single-clock FIFO built from fifo_ctrl
// and ram_2ports. Define FIFO_ALMOST_EN to add almost_full/almost_empty.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef FIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL   = DEFAULT_AF_LEVEL,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
`ifdef FIFO_ALMOST_EN
    ,
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
`endif
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .rd           (rd),
    .we           (we),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Read port is combinational so the head entry falls through to rd_data.
  ram_2ports #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_addr (r_addr),
    .r_data (rd_data)
  );

endmodule
